// File: rtl/pid_pkg.sv
// Shared defaults and saturation helper for the balance PID controller.
package pid_pkg;

  localparam int ERR_W_DEF   = 10;
  localparam int INT_W_DEF   = 18;
  localparam int OUT_W_DEF   = 12;
  localparam int P_COEFF_DEF = 9;
  localparam int I_SHIFT_DEF = 6;
  localparam int D_SHIFT_DEF = 6;
  localparam int TMR_W_DEF   = 27;
  localparam int SS_W_DEF    = 8;
  localparam int SAT_W       = 40;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    hi = (40'sd1 <<< (w - 32'd1)) - 40'sd1;
    lo = -(40'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      res = hi;
    end else if (v < lo) begin
      res = lo;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/soft_start_tmr.sv
// Soft-start timer: ramps the output clamp limit after power-up, then freezes at full scale.
module soft_start_tmr
  import pid_pkg::*;
#(
  parameter int TMR_W    = TMR_W_DEF,
  parameter int SS_W     = SS_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int FAST_SIM = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_up,
  output logic [SS_W-1:0]  ss_tmr,
  output logic [OUT_W-1:0] lim
);

  localparam logic [TMR_W-1:0] INC = (FAST_SIM != 0) ? TMR_W'(256) : TMR_W'(1);

  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             ss_full;

  assign ss_tmr  = tmr_q[TMR_W-1 -: SS_W];
  assign ss_full = &ss_tmr;

  always_comb begin
    tmr_d = tmr_q;
    if (!pwr_up) begin
      tmr_d = '0;
    end else if (ss_full) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + INC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  // Until the ramp completes the limit is the visible timer slice scaled up to the output range.
  always_comb begin
    lim = '0;
    if (ss_full) begin
      lim = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      lim = OUT_W'(ss_tmr) << (OUT_W - 1 - SS_W);
    end
  end

endmodule

// File: rtl/param_pid.sv
// Two-stage pitch PID controller with anti-windup integrator and soft-start output clamp.
module param_pid
  import pid_pkg::*;
#(
  parameter int ERR_W    = ERR_W_DEF,
  parameter int INT_W    = INT_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int P_COEFF  = P_COEFF_DEF,
  parameter int I_SHIFT  = I_SHIFT_DEF,
  parameter int D_SHIFT  = D_SHIFT_DEF,
  parameter int TMR_W    = TMR_W_DEF,
  parameter int SS_W     = SS_W_DEF,
  parameter int FAST_SIM = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  input  logic signed [15:0]      ptch,
  input  logic signed [15:0]      ptch_rt,
  output logic signed [OUT_W-1:0] PID_cntrl,
  output logic                    PID_vld,
  output logic [SS_W-1:0]         ss_tmr,
  output logic                    int_hold
);

  localparam int SW    = INT_W + 1;
  localparam int I_SH  = (FAST_SIM != 0) ? 32'sd1 : I_SHIFT;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic [OUT_W-1:0]        lim_s;
  logic                    clr;
  logic signed [ERR_W-1:0] err;
  logic signed [SW-1:0]    int_sum;
  logic                    ovf;
  logic                    windup;

  logic signed [SW-1:0]    p_d, p_q, d_d, d_q;
  logic                    s1_vld_d, s1_vld_q;
  logic signed [INT_W-1:0] int_d, int_q;
  logic                    int_hold_d, int_hold_q;

  logic signed [INT_W-1:0] i_raw;
  logic signed [SW-1:0]    i_term;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    lim_ext;
  logic signed [OUT_W-1:0] pid_d, pid_q;
  logic                    pid_vld_d, pid_vld_q;

  soft_start_tmr #(
    .TMR_W   (TMR_W),
    .SS_W    (SS_W),
    .OUT_W   (OUT_W),
    .FAST_SIM(FAST_SIM)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .pwr_up(pwr_up),
    .ss_tmr(ss_tmr),
    .lim   (lim_s)
  );

  assign clr     = !pwr_up || rider_off;
  assign err     = ERR_W'(sat_signed(SAT_W'(ptch), ERR_W));
  assign int_sum = SW'(int_q) + SW'(err);
  assign ovf     = int_sum[INT_W] != int_sum[INT_W-1];
  // Stop integrating further into a rail the output is already pinned against.
  assign windup  = ((pid_q == OUT_MAX) && !err[ERR_W-1] && (err != '0)) ||
                   ((pid_q == -OUT_MAX) && err[ERR_W-1]);

  // Stage 1: capture P and D terms and accumulate the integrator.
  always_comb begin
    p_d        = p_q;
    d_d        = d_q;
    s1_vld_d   = 1'b0;
    int_d      = int_q;
    int_hold_d = int_hold_q;
    if (clr) begin
      p_d        = '0;
      d_d        = '0;
      int_d      = '0;
      int_hold_d = 1'b0;
    end else if (vld) begin
      p_d      = SW'(err) * SW'(P_COEFF);
      d_d      = -(SW'(ptch_rt >>> D_SHIFT));
      s1_vld_d = 1'b1;
      if (ovf || windup) begin
        int_hold_d = 1'b1;
      end else begin
        int_d      = int_sum[INT_W-1:0];
        int_hold_d = 1'b0;
      end
    end else begin
      s1_vld_d = 1'b0;
    end
  end

  assign i_raw   = int_q >>> I_SH;
  assign i_term  = SW'(sat_signed(SAT_W'(i_raw), INT_W - 3));
  assign sum     = p_q + i_term + d_q;
  assign lim_ext = $signed(SW'(lim_s));

  // Stage 2: sum the terms and clamp symmetrically to the soft-start limit.
  always_comb begin
    pid_d     = pid_q;
    pid_vld_d = 1'b0;
    if (clr) begin
      pid_d = '0;
    end else if (s1_vld_q) begin
      pid_vld_d = 1'b1;
      if (sum > lim_ext) begin
        pid_d = $signed(lim_s);
      end else if (sum < -lim_ext) begin
        pid_d = -$signed(lim_s);
      end else begin
        pid_d = OUT_W'(sum);
      end
    end else begin
      pid_d = pid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q        <= '0;
      d_q        <= '0;
      s1_vld_q   <= 1'b0;
      int_q      <= '0;
      int_hold_q <= 1'b0;
      pid_q      <= '0;
      pid_vld_q  <= 1'b0;
    end else begin
      p_q        <= p_d;
      d_q        <= d_d;
      s1_vld_q   <= s1_vld_d;
      int_q      <= int_d;
      int_hold_q <= int_hold_d;
      pid_q      <= pid_d;
      pid_vld_q  <= pid_vld_d;
    end
  end

  assign PID_cntrl = pid_q;
  assign PID_vld   = pid_vld_q;
  assign int_hold  = int_hold_q;

endmodule

// File: tb/tb_param_pid.sv
// Directed self-checking bench for param_pid: a short-timer instance and a FAST_SIM instance.
module tb_param_pid;

  logic               clk;
  logic               rst_n;
  logic               vld;
  logic               pwr_up;
  logic               rider_off;
  logic signed [15:0] ptch;
  logic signed [15:0] ptch_rt;
  logic signed [11:0] pid_cntrl;
  logic               pid_vld;
  logic [7:0]         ss_tmr;
  logic               int_hold;

  logic               pwr_up_f;
  logic               vld_f;
  logic               rider_off_f;
  logic signed [15:0] ptch_f;
  logic signed [15:0] ptch_rt_f;
  logic signed [11:0] pid_cntrl_f;
  logic               pid_vld_f;
  logic [7:0]         ss_tmr_f;
  logic               int_hold_f;

  int total;
  int bad;

  param_pid #(.TMR_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .pwr_up(pwr_up), .rider_off(rider_off),
    .ptch(ptch), .ptch_rt(ptch_rt), .PID_cntrl(pid_cntrl), .PID_vld(pid_vld),
    .ss_tmr(ss_tmr), .int_hold(int_hold)
  );

  param_pid #(.TMR_W(19), .FAST_SIM(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .vld(vld_f), .pwr_up(pwr_up_f), .rider_off(rider_off_f),
    .ptch(ptch_f), .ptch_rt(ptch_rt_f), .PID_cntrl(pid_cntrl_f), .PID_vld(pid_vld_f),
    .ss_tmr(ss_tmr_f), .int_hold(int_hold_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; vld = 1'b0; pwr_up = 1'b1; rider_off = 1'b0; ptch = '0; ptch_rt = '0;
    pwr_up_f = 1'b0; vld_f = 1'b0; rider_off_f = 1'b0; ptch_f = '0; ptch_rt_f = '0;

    // reset wins over an asserted pwr_up
    repeat (2) tick();
    chk("rst_pid", pid_cntrl, 0);
    chk("rst_vld", pid_vld, 0);
    chk("rst_hold", int_hold, 0);
    chk("rst_ss", ss_tmr, 0);
    chk("rst_int", u_dut.int_q, 0);
    chk("rst_ss_fast", ss_tmr_f, 0);

    rst_n = 1'b1; pwr_up = 1'b0;
    tick();
    chk("pwr_low_ss", ss_tmr, 0);

    // ramp: ss_tmr = timer >> 2; limit 4 << 3 = 32
    pwr_up = 1'b1;
    repeat (16) tick();
    chk("ss_is_4", ss_tmr, 4);
    vld = 1'b1; ptch = 16'sd100;
    tick();
    vld = 1'b0;
    chk("lim32_n1_vld", pid_vld, 0);
    tick();
    chk("lim32_pid", pid_cntrl, 32);
    chk("lim32_vld", pid_vld, 1);

    repeat (1010) tick();
    chk("ss_sat", ss_tmr, 255);

    // rider_off while a sample sits in stage 1
    vld = 1'b1; ptch = 16'sd100;
    tick();
    vld = 1'b0; rider_off = 1'b1;
    tick();
    rider_off = 1'b0;
    chk("roff_vld", pid_vld, 0);
    chk("roff_pid", pid_cntrl, 0);
    chk("roff_int", u_dut.int_q, 0);
    chk("roff_ss", ss_tmr, 255);
    tick();
    chk("roff_vld_late", pid_vld, 0);

    // nominal: 100*9 + (100>>>6) = 901
    vld = 1'b1; ptch = 16'sd100; ptch_rt = 16'sd0;
    tick();
    vld = 1'b0;
    chk("nom_n1_vld", pid_vld, 0);
    tick();
    chk("nom_pid", pid_cntrl, 901);
    chk("nom_vld", pid_vld, 1);
    chk("nom_hold", int_hold, 0);
    tick();
    chk("nom_n3_vld", pid_vld, 0);
    chk("nom_n3_pid", pid_cntrl, 901);

    rider_off = 1'b1;
    tick();
    rider_off = 1'b0;
    chk("clr_pid", pid_cntrl, 0);

    // derivative only: -(640>>>6) = -10
    vld = 1'b1; ptch = 16'sd0; ptch_rt = 16'sd640;
    tick();
    vld = 1'b0;
    tick();
    chk("d_pid", pid_cntrl, -10);
    chk("d_vld", pid_vld, 1);

    rider_off = 1'b1; ptch_rt = 16'sd0;
    tick();
    rider_off = 1'b0;

    // err saturates to 511; anti-windup freezes the integrator once output hits 2047
    for (int k = 0; k < 5; k++) begin
      vld = 1'b1; ptch = 16'sd1000;
      tick();
      vld = 1'b0;
      tick();
      chk("wind_pid", pid_cntrl, 2047);
      chk("wind_int", u_dut.int_q, 511);
      chk("wind_hold", int_hold, (k == 0) ? 0 : 1);
      tick();
    end

    // err saturates to -512: 511-512=-1, sum=-4608-1 -> clamp -2047
    vld = 1'b1; ptch = -16'sd1000;
    tick();
    vld = 1'b0;
    tick();
    chk("neg_pid", pid_cntrl, -2047);
    chk("neg_int", u_dut.int_q, -1);
    chk("neg_hold", int_hold, 0);

    rider_off = 1'b1;
    tick();
    rider_off = 1'b0;

    // back-to-back samples
    vld = 1'b1; ptch = 16'sd10;
    tick();
    ptch = -16'sd10;
    tick();
    vld = 1'b0;
    chk("b2b_a_pid", pid_cntrl, 90);
    chk("b2b_a_vld", pid_vld, 1);
    tick();
    chk("b2b_b_pid", pid_cntrl, -90);
    chk("b2b_b_vld", pid_vld, 1);
    tick();
    chk("b2b_end_vld", pid_vld, 0);

    // vld coincident with pwr_up low is discarded
    pwr_up = 1'b0; vld = 1'b1; ptch = 16'sd100;
    tick();
    vld = 1'b0;
    chk("pwr_ss", ss_tmr, 0);
    chk("pwr_pid", pid_cntrl, 0);
    chk("pwr_vld0", pid_vld, 0);
    pwr_up = 1'b1;
    tick();
    chk("pwr_vld1", pid_vld, 0);
    tick();
    chk("pwr_vld2", pid_vld, 0);

    // FAST_SIM: step 256/cycle, ss_tmr = timer[18:11]
    pwr_up_f = 1'b1;
    repeat (2039) tick();
    chk("fast_ss_254", ss_tmr_f, 254);
    tick();
    chk("fast_ss_255", ss_tmr_f, 255);
    repeat (20) tick();
    chk("fast_ss_hold", ss_tmr_f, 255);
    pwr_up_f = 1'b0;
    tick();
    chk("fast_ss_clr", ss_tmr_f, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
